// File: rtl/keystream_serializer_pkg.sv
//------------------------------------------------------------------------------
// keystream_serializer_pkg : ChaCha20 matrix types shared with the block function
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package keystream_serializer_pkg;

    typedef logic [31:0] word_t;

    localparam int CHACHA_BLOCK_BYTES = 64;
    localparam int CHACHA_WORDS       = 16;
    localparam int CHACHA_BLOCK_BITS  = 8 * CHACHA_BLOCK_BYTES;

    // Word w of the block lives at [w/4][w%4].
    typedef word_t [3:0][3:0] chacha_matrix_t;

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/ks_beat_mux.sv
//------------------------------------------------------------------------------
// ks_beat_mux : selects beat i (BEAT_BYTES wide) from a flattened 64-byte block
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ks_beat_mux
    import keystream_serializer_pkg::*;
#(
    parameter  int BEAT_BYTES = 4,
    localparam int BEATS      = CHACHA_BLOCK_BYTES / BEAT_BYTES,
    localparam int BEAT_W     = $clog2(BEATS)
) (
    input  logic [CHACHA_BLOCK_BITS-1:0] block_i,
    input  logic [BEAT_W-1:0]            beat_i,
    output logic [8*BEAT_BYTES-1:0]      beat_o
);

    logic [8*BEAT_BYTES-1:0] w_beats [BEATS];

    for (genvar i = 0; i < BEATS; i++) begin : g_beat
        assign w_beats[i] = block_i[i*8*BEAT_BYTES +: 8*BEAT_BYTES];
    end

    assign beat_o = w_beats[beat_i];

endmodule

`default_nettype wire

// File: rtl/keystream_serializer.sv
//------------------------------------------------------------------------------
// keystream_serializer : double-buffered ChaCha20 keystream to byte-beat stream
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keystream_serializer
    import keystream_serializer_pkg::*;
#(
    parameter int BEAT_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  chacha_matrix_t          matrix_in,
    input  logic                    load,
    output logic [8*BEAT_BYTES-1:0] ks_data,
    output logic                    ks_valid,
    input  logic                    ks_ready,
    output logic                    ks_last,
    output logic                    can_load,
    output logic                    overflow,
    output logic [31:0]             blocks_out
);

    localparam int BEATS  = CHACHA_BLOCK_BYTES / BEAT_BYTES;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (BEAT_BYTES != 1 && BEAT_BYTES != 2 && BEAT_BYTES != 4) begin : g_bad_beat_bytes
        $error("keystream_serializer: BEAT_BYTES must be 1, 2 or 4");
    end

    ser_state_t                    state_q, state_d;
    logic [CHACHA_BLOCK_BITS-1:0]  active_q, active_d;
    logic [CHACHA_BLOCK_BITS-1:0]  pending_q, pending_d;
    logic                          pend_full_q, pend_full_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic                          overflow_q, overflow_d;
    logic [31:0]                   blocks_q, blocks_d;
    logic [8*BEAT_BYTES-1:0]       data_q;
    logic                          valid_q;
    logic                          last_q;

    logic [CHACHA_BLOCK_BITS-1:0]  w_load_blk;
    logic [8*BEAT_BYTES-1:0]       w_next_beat;
    logic                          w_fire;
    logic                          w_last_fire;

    for (genvar w = 0; w < CHACHA_WORDS; w++) begin : g_flatten
        assign w_load_blk[32*w +: 32] = matrix_in[w/4][w%4];
    end

    assign w_fire      = valid_q && ks_ready;
    assign w_last_fire = w_fire && (beat_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        beat_d      = beat_q;
        overflow_d  = overflow_q;
        blocks_d    = blocks_q;

        case (state_q)
            EMPTY: begin
                if (load) begin
                    active_d = w_load_blk;
                    beat_d   = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (w_fire) begin
                    beat_d = beat_q + 1'b1;
                end
                if (w_last_fire) begin
                    blocks_d = blocks_q + 32'd1;
                    beat_d   = '0;
                    if (pend_full_q) begin
                        // Promote pending; a coincident load refills it, so nothing is lost.
                        active_d = pending_q;
                        if (load) begin
                            pending_d = w_load_blk;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (load) begin
                        active_d = w_load_blk;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (load) begin
                    if (!pend_full_q) begin
                        pending_d   = w_load_blk;
                        pend_full_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Outputs are computed from next state so they are registered yet current.
    ks_beat_mux #(
        .BEAT_BYTES (BEAT_BYTES)
    ) u_beat_mux (
        .block_i (active_d),
        .beat_i  (beat_d),
        .beat_o  (w_next_beat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            pend_full_q <= 1'b0;
            beat_q      <= '0;
            overflow_q  <= 1'b0;
            blocks_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            beat_q      <= beat_d;
            overflow_q  <= overflow_d;
            blocks_q    <= blocks_d;
            data_q      <= (state_d == STREAM) ? w_next_beat : '0;
            valid_q     <= (state_d == STREAM);
            last_q      <= (state_d == STREAM) && (beat_d == LAST_BEAT);
        end
    end

    always_ff @(posedge clk) begin
        active_q  <= active_d;
        pending_q <= pending_d;
    end

    assign ks_data    = data_q;
    assign ks_valid   = valid_q;
    assign ks_last    = last_q;
    assign overflow   = overflow_q;
    assign blocks_out = blocks_q;
    assign can_load   = !((state_q == STREAM) && pend_full_q);

endmodule

`default_nettype wire

// File: tb/tb_keystream_serializer.sv
//------------------------------------------------------------------------------
// tb_keystream_serializer : scoreboard + vector-table bench, BEAT_BYTES 4 and 1
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_keystream_serializer;
    import keystream_serializer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b0;
    chacha_matrix_t m4 = '0, m1 = '0;
    logic           load4 = 1'b0, load1 = 1'b0, ready4 = 1'b0, ready1 = 1'b0;
    logic [31:0]    data4, blk4, blk1;
    logic [7:0]     data1;
    logic           valid4, last4, canl4, ovf4;
    logic           valid1, last1, canl1, ovf1;

    keystream_serializer #(.BEAT_BYTES(4)) u_dut4 (
        .clk(clk), .rst(rst), .matrix_in(m4), .load(load4),
        .ks_data(data4), .ks_valid(valid4), .ks_ready(ready4), .ks_last(last4),
        .can_load(canl4), .overflow(ovf4), .blocks_out(blk4)
    );

    keystream_serializer #(.BEAT_BYTES(1)) u_dut1 (
        .clk(clk), .rst(rst), .matrix_in(m1), .load(load1),
        .ks_data(data1), .ks_valid(valid1), .ks_ready(ready1), .ks_last(last1),
        .can_load(canl1), .overflow(ovf1), .blocks_out(blk1)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          beat;
        logic [31:0] data;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    beat_t        q4[$], q1[$];
    logic [31:0]  log4[$], log1[$];
    beat_t        e4, e1;
    logic         stall4 = 1'b0, stall1 = 1'b0;
    logic [31:0]  hold4, hold1;
    int           gap4 = 0;
    vec_t         tbl4[4], tbl1[6];
    chacha_matrix_t ma, mb, mc, md, me;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic chacha_matrix_t rfc_matrix();
        chacha_matrix_t m;
        word_t w [16] = '{
            32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
            32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
            32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
            32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = w[4*r+c];
        return m;
    endfunction

    function automatic chacha_matrix_t rnd_matrix();
        chacha_matrix_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = $urandom;
        return m;
    endfunction

    // Expected beats: byte k is byte k%4 of word k/4; beats gather bb bytes, lowest first.
    task automatic push_block(input chacha_matrix_t m, input int bb);
        logic [31:0] acc;
        word_t       w;
        beat_t       e;
        acc = '0;
        for (int k = 0; k < 64; k++) begin
            w = m[k/16][(k/4)%4];
            acc[8*(k%bb) +: 8] = w[8*(k%4) +: 8];
            if (k % bb == bb - 1) begin
                e.data = acc;
                e.last = (k == 63);
                if (bb == 4) q4.push_back(e);
                else         q1.push_back(e);
                acc = '0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            stall4 = 1'b0;
        end else begin
            if (stall4) begin
                chk("stall_valid4", valid4, 1);
                chk("stall_data4", data4, hold4);
            end
            if (valid4 && ready4) begin
                log4.push_back(data4);
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat4: got unexpected beat 0x%08h expected none", data4);
                end else begin
                    e4 = q4.pop_front();
                    chk("data4", data4, e4.data);
                    chk("last4", last4, e4.last);
                end
            end else if (ready4 && !valid4 && q4.size() > 0) begin
                gap4++;
            end
            stall4 = valid4 && !ready4;
            hold4  = data4;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            stall1 = 1'b0;
        end else begin
            if (stall1) begin
                chk("stall_valid1", valid1, 1);
                chk("stall_data1", data1, hold1);
            end
            if (valid1 && ready1) begin
                log1.push_back(data1);
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat1: got unexpected beat 0x%02h expected none", data1);
                end else begin
                    e1 = q1.pop_front();
                    chk("data1", data1, e1.data);
                    chk("last1", last1, e1.last);
                end
            end
            stall1 = valid1 && !ready1;
            hold1  = data1;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; load4 = 1'b0; load1 = 1'b0; ready4 = 1'b0; ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q4.delete(); q1.delete(); log4.delete(); log1.delete();
    endtask

    task automatic load_blk4(input chacha_matrix_t m);
        @(posedge clk); #1;
        m4 = m; load4 = 1'b1;
        @(posedge clk); #1;
        load4 = 1'b0;
    endtask

    task automatic wait_drain4(input string name);
        int n = 0;
        while (q4.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) fail_now(name);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl4[0] = '{0,  32'he4e7f110};
        tbl4[1] = '{1,  32'h15593bd1};
        tbl4[2] = '{4,  32'hc7f4d1c7};
        tbl4[3] = '{15, 32'h4e3c50a2};
        tbl1[0] = '{0,  32'h10};
        tbl1[1] = '{1,  32'hf1};
        tbl1[2] = '{2,  32'he7};
        tbl1[3] = '{3,  32'he4};
        tbl1[4] = '{4,  32'hd1};
        tbl1[5] = '{63, 32'h4e};
        ma = rfc_matrix();
        mb = rnd_matrix(); mc = rnd_matrix(); md = rnd_matrix(); me = rnd_matrix();

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_valid", valid4, 0);
        chk("rst_last", last4, 0);
        chk("rst_ovf", ovf4, 0);
        chk("rst_blocks", blk4, 0);
        chk("rst_can_load", canl4, 1);
        chk("rst_data", data4, 0);
        chk("rst_valid1", valid1, 0);

        // RFC block, 4-byte beats, ready held high
        @(posedge clk); #1;
        ready4 = 1'b1; m4 = ma; load4 = 1'b1;
        push_block(ma, 4);
        @(negedge clk);
        chk("latency_lo", valid4, 0);
        @(posedge clk); #1;
        load4 = 1'b0;
        @(negedge clk);
        chk("latency_hi", valid4, 1);
        wait_drain4("t1_drain");
        chk("t1_blocks", blk4, 1);
        chk("t1_valid_after", valid4, 0);
        chk("t1_beats", log4.size(), 16);
        foreach (tbl4[i]) begin
            if (tbl4[i].beat < log4.size()) chk($sformatf("t1_vec%0d", tbl4[i].beat), log4[tbl4[i].beat], tbl4[i].data);
            else fail_now($sformatf("t1_vec%0d", tbl4[i].beat));
        end

        // RFC block, 1-byte beats, ready toggling
        @(posedge clk); #1;
        m1 = ma; load1 = 1'b1;
        push_block(ma, 1);
        @(posedge clk); #1;
        load1 = 1'b0;
        n = 0;
        while (q1.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            ready1 = ~ready1;
            n++;
        end
        if (q1.size() != 0) fail_now("t2_drain");
        @(negedge clk);
        chk("t2_blocks", blk1, 1);
        chk("t2_valid_after", valid1, 0);
        chk("t2_beats", log1.size(), 64);
        foreach (tbl1[i]) begin
            if (tbl1[i].beat < log1.size()) chk($sformatf("t2_vec%0d", tbl1[i].beat), log1[tbl1[i].beat], tbl1[i].data);
            else fail_now($sformatf("t2_vec%0d", tbl1[i].beat));
        end

        // Three loads while stalled: third is dropped
        do_reset();
        load_blk4(ma); push_block(ma, 4);
        load_blk4(mb); push_block(mb, 4);
        load_blk4(mc);
        @(negedge clk);
        chk("t3_overflow", ovf4, 1);
        chk("t3_can_load", canl4, 0);
        chk("t3_valid", valid4, 1);
        @(posedge clk); #1;
        ready4 = 1'b1; gap4 = 0;
        wait_drain4("t3_drain");
        chk("t3_blocks", blk4, 2);
        chk("t3_gap", gap4, 0);
        chk("t3_overflow_sticky", ovf4, 1);
        chk("t3_beats", log4.size(), 32);

        // Load coincident with last beat while both buffers full
        do_reset();
        load_blk4(ma); push_block(ma, 4);
        load_blk4(mb); push_block(mb, 4);
        @(negedge clk);
        chk("t4_can_load", canl4, 0);
        @(posedge clk); #1;
        ready4 = 1'b1; gap4 = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!last4 && n < 100);
        if (!last4) fail_now("t4_wait_last");
        m4 = md; load4 = 1'b1;
        push_block(md, 4);
        @(posedge clk); #1;
        load4 = 1'b0;
        wait_drain4("t4_drain");
        chk("t4_blocks", blk4, 3);
        chk("t4_overflow", ovf4, 0);
        chk("t4_gap", gap4, 0);
        chk("t4_beats", log4.size(), 48);

        // Reset mid-block, load during reset ignored, then fresh block
        do_reset();
        ready4 = 1'b1;
        load_blk4(ma); push_block(ma, 4);
        n = 0;
        while (log4.size() < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (log4.size() < 7) fail_now("t5_wait_beat7");
        rst = 1'b0;
        m4 = me; load4 = 1'b1;
        @(negedge clk);
        chk("t5_valid", valid4, 0);
        chk("t5_last", last4, 0);
        chk("t5_data", data4, 0);
        chk("t5_blocks", blk4, 0);
        chk("t5_can_load", canl4, 1);
        @(posedge clk); #1;
        rst = 1'b1; load4 = 1'b0;
        q4.delete(); log4.delete();
        @(negedge clk);
        chk("t5_load_in_reset", valid4, 0);
        load_blk4(me); push_block(me, 4);
        wait_drain4("t5_drain");
        chk("t5_blocks_after", blk4, 1);
        chk("t5_beats", log4.size(), 16);

        // blocks_out wraps
        do_reset();
        @(negedge clk);
        force u_dut4.blocks_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release u_dut4.blocks_q;
        @(negedge clk);
        chk("t6_preload", blk4, 32'hFFFF_FFFF);
        ready4 = 1'b1;
        load_blk4(mb); push_block(mb, 4);
        wait_drain4("t6_drain");
        chk("t6_wrap", blk4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
